// File: rtl/cla_chunked_subtractor.sv
// Multi-cycle chunked subtractor: o_data = i_data_one - i_data_two.
// One CLA slice (a + ~b + cin) is resolved per cycle, with the carry held between cycles.
//
// Ports:
//   i_clk, i_rst          rising-edge clock, synchronous active-high reset
//   i_valid / o_ready     operand handshake (o_ready high only in IDLE)
//   i_data_one/_two       minuend / subtrahend
//   o_valid / i_ready     result handshake (result held under backpressure)
//   o_data                difference modulo 2^DATA_WIDTH
//   o_borrow              unsigned borrow (inverse of the final carry)
//   o_overflow            signed overflow, present only with CLA_SUB_OVERFLOW_EN
//
// Build option: define CLA_SUB_OVERFLOW_EN to add the o_overflow port and its logic.

module cla_chunked_subtractor #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data_one,
  input  logic [DATA_WIDTH-1:0] i_data_two,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
`ifdef CLA_SUB_OVERFLOW_EN
  output logic                  o_overflow,
`endif
  output logic                  o_borrow
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if ((DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_cfg
    $error("DATA_WIDTH must be a multiple of CHUNK_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    carry_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [DATA_WIDTH-1:0]   res_q;
  logic [DATA_WIDTH-1:0]   res_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    borrow_q;
  logic                    valid_q;
  logic                    ready_q;
`ifdef CLA_SUB_OVERFLOW_EN
  logic                    ovf_q;
  logic                    ovf_d;
`endif

  logic [CHUNK_WIDTH-1:0]  a_sl;
  logic [CHUNK_WIDTH-1:0]  nb_sl;
  logic [CHUNK_WIDTH-1:0]  g;
  logic [CHUNK_WIDTH-1:0]  p;
  logic [CHUNK_WIDTH:0]    c;
  logic [CHUNK_WIDTH-1:0]  sum;
  logic                    cout;
  logic                    last;

  // Current slice; subtraction is a + ~b with carry-in seeded to 1.
  always_comb begin
    a_sl  = a_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
    nb_sl = ~b_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
    g     = a_sl & nb_sl;
    p     = a_sl ^ nb_sl;
  end

  // Lookahead carries: every c[i+1] is a flat sum of products of
  // g/p and the slice carry-in, so no carry ripples bit to bit.
  always_comb begin : p_cla
    logic pr;
    pr   = 1'b1;
    c    = '0;
    c[0] = carry_q;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      c[i+1] = g[i];
      pr     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pr & g[j]);
        pr     = pr & p[j];
      end
      c[i+1] = c[i+1] | (pr & carry_q);
    end
  end

  always_comb begin
    sum   = p ^ c[CHUNK_WIDTH-1:0];
    cout  = c[CHUNK_WIDTH];
    last  = (int'(idx_q) == NUM_CHUNKS - 1);
    res_d = res_q;
    res_d[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] = sum;
  end

`ifdef CLA_SUB_OVERFLOW_EN
  // The final slice carries the MSB of the difference.
  always_comb begin
    ovf_d = (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]) &
            (sum[CHUNK_WIDTH-1] != a_q[DATA_WIDTH-1]);
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      data_q   <= '0;
      borrow_q <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
`ifdef CLA_SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_valid && ready_q) begin
            a_q     <= i_data_one;
            b_q     <= i_data_two;
            idx_q   <= '0;
            carry_q <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          res_q   <= res_d;
          carry_q <= cout;
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            data_q   <= res_d;
            borrow_q <= ~cout;
`ifdef CLA_SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_borrow   = borrow_q;
`ifdef CLA_SUB_OVERFLOW_EN
  assign o_overflow = ovf_q;
`endif

endmodule
